// File: rtl/audio_pkg.sv
// Shared definitions for the audio playback scheduler and the Audio block it drives.
package audio_pkg;

  localparam int unsigned AUDIO_TRACK_W = 16;
  localparam int unsigned AUDIO_VOL_W   = 4;
  localparam logic [AUDIO_VOL_W-1:0] AUDIO_MUTE_CODE = 4'd0;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    PLAY,
    GAP
  } state_t;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/audio_prio_enc.sv
// Lowest-index-first priority encoder: reports whether any request is set and the winning index.
module audio_prio_enc #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  output logic               any,
  output logic [ID_W-1:0]    index
);

  // Scan upward and keep the first set bit.
  always_comb begin
    any   = 1'b0;
    index = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req[i] && !any) begin
        any   = 1'b1;
        index = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/audio_track_scheduler.sv
// Shares the single Audio/I2S playback block between prioritised requesters:
// grant -> load pulse -> timed playback -> muted gap -> idle.
module audio_track_scheduler
  import audio_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned TRACK_W     = AUDIO_TRACK_W,
  parameter int unsigned VOL_W       = AUDIO_VOL_W,
  parameter int unsigned INIT_CYCLES = 4,
  parameter int unsigned PLAY_CYCLES = 100000000,
  parameter int unsigned GAP_CYCLES  = 1000,
  parameter logic [VOL_W-1:0] MUTE_CODE = AUDIO_MUTE_CODE
) (
  input  logic                         CLK,
  input  logic                         Reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*TRACK_W-1:0]   req_track,
  input  logic [NUM_REQ*VOL_W-1:0]     req_volume,
  output logic [NUM_REQ-1:0]           req_ack,
  output logic [VOL_W-1:0]             AudioControlRegister,
  output logic [TRACK_W-1:0]           SoundTrackInitializationRegister,
  output logic                         InitializationEnableRegister,
  output logic                         busy,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] active_id
);

  localparam int unsigned ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(max3(INIT_CYCLES, PLAY_CYCLES, GAP_CYCLES) + 1);

  localparam logic [CNT_W-1:0]   INIT_LOAD = CNT_W'(INIT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   PLAY_LOAD = CNT_W'(PLAY_CYCLES - 1);
  localparam logic [CNT_W-1:0]   GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [NUM_REQ-1:0] ACK_ONE   = NUM_REQ'(1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               req_any;
  logic [ID_W-1:0]    grant_idx;
  logic [TRACK_W-1:0] sel_track;
  logic [VOL_W-1:0]   sel_volume;
  logic               preempt;

  // One encoder serves both the IDLE grant and the PLAY preemption test.
  audio_prio_enc #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_prio_enc (
    .req   (req_valid),
    .any   (req_any),
    .index (grant_idx)
  );

  // Select the winning requester's track and control code, and detect a higher-priority request.
  always_comb begin
    sel_track  = req_track[grant_idx*TRACK_W +: TRACK_W];
    sel_volume = req_volume[grant_idx*VOL_W +: VOL_W];
    preempt    = req_any && (grant_idx < active_id);
  end

  // Sequencer with registered outputs; the track/volume output registers double as the latched request.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state                            <= IDLE;
      cnt                              <= '0;
      req_ack                          <= '0;
      busy                             <= 1'b0;
      active_id                        <= '0;
      AudioControlRegister             <= MUTE_CODE;
      SoundTrackInitializationRegister <= '0;
      InitializationEnableRegister     <= 1'b0;
    end else begin
      req_ack <= '0;
      case (state)
        IDLE: begin
          if (req_any) begin
            state                            <= LOAD;
            cnt                              <= INIT_LOAD;
            req_ack                          <= ACK_ONE << grant_idx;
            active_id                        <= grant_idx;
            busy                             <= 1'b1;
            SoundTrackInitializationRegister <= sel_track;
            AudioControlRegister             <= sel_volume;
            InitializationEnableRegister     <= 1'b1;
          end
        end
        LOAD: begin
          if (cnt == '0) begin
            state                        <= PLAY;
            cnt                          <= PLAY_LOAD;
            InitializationEnableRegister <= 1'b0;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        PLAY: begin
          if (preempt || cnt == '0) begin
            state                <= GAP;
            cnt                  <= GAP_LOAD;
            AudioControlRegister <= MUTE_CODE;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        GAP: begin
          if (cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
